// File: rtl/ps2_key_ctrl_if.sv
// rtl/ps2_key_ctrl_if.sv - scancode input and key event output bundle for ps2_key_ctrl
interface ps2_key_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;

  modport master (
    output rx_data, rx_ready, key_ack,
    input  key_code, key_valid, overflow
  );

  modport slave (
    input  rx_data, rx_ready, key_ack,
    output key_code, key_valid, overflow
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 set-2 scancode decoder feeding a small key event FIFO
// Only make codes produce events; prefixed sequences abandon after TIMEOUT_CYCLES idle clocks.
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input logic           clk,
  input logic           reset,
  ps2_key_ctrl_if.slave kbd
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t             r_state, w_next_state;
  logic [TMO_W-1:0]   r_tmo;
  logic [4:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               w_push, w_pop, w_full, w_wr, w_tmo_hit;
  logic [4:0]         w_push_code, w_base_code, w_ext_code;

  function automatic logic [4:0] f_base_map(input logic [7:0] b);
    case (b)
      8'h16, 8'h69: return 5'h01;
      8'h1E, 8'h72: return 5'h02;
      8'h26, 8'h7A: return 5'h03;
      8'h25, 8'h6B: return 5'h04;
      8'h2E, 8'h73: return 5'h05;
      8'h36, 8'h74: return 5'h06;
      8'h3D, 8'h6C: return 5'h07;
      8'h3E, 8'h75: return 5'h08;
      8'h46, 8'h7D: return 5'h09;
      8'h45, 8'h70, 8'h66: return 5'h0E;
      8'h5A: return 5'h0F;
      8'h76: return 5'h10;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [4:0] f_ext_map(input logic [7:0] b);
    case (b)
      8'h75: return 5'h0A;
      8'h72: return 5'h0B;
      8'h6B: return 5'h0C;
      8'h74: return 5'h0D;
      8'h71: return 5'h0E;
      8'h5A: return 5'h0F;
      default: return 5'h00;
    endcase
  endfunction

  assign w_base_code = f_base_map(kbd.rx_data);
  assign w_ext_code  = f_ext_map(kbd.rx_data);
  // A fresh byte always wins over the timeout on the same cycle
  assign w_tmo_hit   = (r_state != IDLE) && !kbd.rx_ready && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE || kbd.rx_ready || w_tmo_hit) r_tmo <= '0;
      else                                               r_tmo <= r_tmo + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_code  = 5'h00;
    if (w_tmo_hit) begin
      w_next_state = IDLE;
    end else if (kbd.rx_ready) begin
      case (r_state)
        IDLE: begin
          if (kbd.rx_data == 8'hE0)      w_next_state = EXT;
          else if (kbd.rx_data == 8'hF0) w_next_state = BRK;
          else if (w_base_code != 5'h00) begin
            w_push      = 1'b1;
            w_push_code = w_base_code;
          end
        end
        EXT: begin
          if (kbd.rx_data == 8'hF0)      w_next_state = EXT_BRK;
          else if (kbd.rx_data == 8'hE0) w_next_state = EXT;
          else begin
            w_next_state = IDLE;
            if (w_ext_code != 5'h00) begin
              w_push      = 1'b1;
              w_push_code = w_ext_code;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = kbd.key_ack && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= w_push && w_full && !w_pop;
    end
  end

  assign kbd.key_valid = (r_count != '0);
  assign kbd.key_code  = (r_count != '0) ? r_mem[r_rd_ptr] : 5'h00;
  assign kbd.overflow  = r_overflow;
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: idle clocks after a prefix byte before the decoder abandons the sequence.
REQ-002 Parameter FIFO_DEPTH, default 4: key event buffer depth; power of two, minimum 2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces all state to reset values immediately.
REQ-005 rx_data  input  8  scancode byte from the PS/2 receiver; valid only while rx_ready is high.
REQ-006 rx_ready  input  1  one-cycle strobe from the PS/2 receiver marking a new byte.
REQ-007 key_code  output  5  event code at FIFO head; 1-9 digit, 0x0A up, 0x0B down, 0x0C left, 0x0D right, 0x0E clear, 0x0F enter, 0x10 escape.
REQ-008 key_valid  output  1  high while the FIFO is non-empty.
REQ-009 key_ack  input  1  consumer pop; when high with key_valid high, the head is removed on that edge.
REQ-010 overflow  output  1  one-cycle pulse when a mapped event is dropped because the FIFO is full.

Function
REQ-011 Decoder FSM states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 0xF0 seen); it advances only on cycles with rx_ready high.
REQ-012 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; a mapped base code pushes its event and stays in IDLE; all other bytes (0xAA, 0xFA, 0xFE, 0xEE, 0xE1, unmapped) are discarded and the FSM stays in IDLE.
REQ-013 Base map: 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> 1..9; keypad 0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D -> 1..9; 0x45, 0x70, 0x66 -> 0x0E; 0x5A -> 0x0F; 0x76 -> 0x10.
REQ-014 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; 0x75/0x72/0x6B/0x74 -> push 0x0A/0x0B/0x0C/0x0D; 0x71 -> push 0x0E; 0x5A -> push 0x0F; a mapped byte or any other byte returns the FSM to IDLE.
REQ-015 BRK and EXT_BRK: the next byte of any value is consumed with no event, and the FSM returns to IDLE; release events are never emitted.
REQ-016 Repeated make codes (typematic) each push a separate event.
REQ-017 Timeout counter: cleared on every rx_ready and held at zero in IDLE; in EXT, BRK, or EXT_BRK, reaching TIMEOUT_CYCLES forces IDLE with no event.
REQ-018 Push latency: rx_ready with a mapped byte at edge N makes the event visible at the FIFO tail after edge N; key_valid rises after edge N when the FIFO was empty.
REQ-019 key_code is the FIFO head and is held stable while key_valid is high and key_ack is low; key_code is 0 while the FIFO is empty.
REQ-020 FIFO order is strictly first-in first-out; pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-021 Full with no pop: a push is dropped, the contents are unchanged, and overflow pulses for one cycle.
REQ-022 Full with a simultaneous pop: both the push and the pop occur, occupancy stays FIFO_DEPTH, and overflow stays low.
REQ-023 Empty with a simultaneous push: the push occurs, and key_ack is ignored because key_valid is low.
REQ-024 key_ack while key_valid is low has no effect.

Reset
REQ-025 On reset low: FSM = IDLE, timeout counter = 0, FIFO pointers and count = 0, key_valid = 0, key_code = 0, overflow = 0.
REQ-026 Reset asserted in the middle of a sequence (for example, in EXT) discards the partial sequence and all buffered events; the first byte after release is decoded from IDLE.
REQ-027 Outputs are driven from registers or the FIFO head only; the block has no combinational path from rx_data to key_valid.

Verification
REQ-028 Bytes 0x16, then 0xF0 0x16 -> exactly one event, key_code = 0x01, key_valid high one cycle after the 0x16 strobe; the release produces no event.
REQ-029 Bytes 0xE0 0x75, then 0xE0 0xF0 0x75 -> one event, key_code = 0x0A; the FSM returns to IDLE.
REQ-030 Five mapped presses (0x16, 0x1E, 0x26, 0x25, 0x2E) with key_ack low and FIFO_DEPTH = 4 -> events 1, 2, 3, 4 held and a single overflow pulse on the fifth; acks then drain 1, 2, 3, 4 in order.
REQ-031 FIFO full, key_ack high on the same cycle as a new 0x46 strobe -> head popped, 0x09 appended, overflow stays low, count stays 4.
REQ-032 0xE0 followed by TIMEOUT_CYCLES idle clocks, then 0x75 -> the FSM times out to IDLE, and 0x75 decodes as keypad 8 (key_code = 0x08), not up.
REQ-033 Reset pulsed low while in BRK with 2 events queued -> key_valid = 0 immediately; the next byte 0x3E after release yields key_code = 0x08.
